mips_multicycle_control: RTL and testbench

Multicycle main control unit for the MIPS core. Sequences the shared datapath (one memory port, one ALU, register file, IR, PC) through fetch, decode, execute, memory and writeback steps. Drives the 2-bit `aluOp` consumed by `alucontrol`, and all datapath mux selects and write enables. Waits on a memory-ready handshake so that variable-latency memory stalls the machine cleanly.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/mips_ctrl_decode.sv | 101 ++++++++++
 rtl/mips_multicycle_control.sv | 79 +++++++
 tb/tb_mips_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, control FSM states,
// ALU operation classes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    // aluOp classes, decoded further by alucontrol
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore outputs decoded purely from the state (and opcode in DECODE)
    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       regWrite;
        logic       pcEn;
        logic       iord;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       regDst;
        logic       memToReg;
        logic [1:0] aluOp;
        logic       instrDone;
        logic       illegal;
    } ctrl_t;

    // Requests for outputs that the top gates with live inputs
    typedef struct packed {
        logic waitReady;
        logic fetchEn;
        logic beqZeroEn;
        logic doneOnReady;
    } gate_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the control FSM: state + opcode to Moore outputs,
// handshake gating requests and the next state assuming memory is ready.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    output ctrl_t      o_ctrl,
    output gate_t      o_gate,
    output state_t     o_next
);

    always_comb begin
        o_ctrl = '0;
        o_gate = '0;
        o_next = S_FETCH;
        case (i_state)
            S_FETCH: begin
                o_ctrl.memReq   = 1'b1;
                o_ctrl.aluSrcB  = ALUSRCB_FOUR;
                o_gate.waitReady = 1'b1;
                o_gate.fetchEn   = 1'b1;
                o_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                o_ctrl.aluSrcB = ALUSRCB_IMMSH;
                case (i_opcode)
                    OP_LW, OP_SW: o_next = S_MEMADR;
                    OP_RTYPE:     o_next = S_RTYPEEX;
                    OP_BEQ:       o_next = S_BEQEX;
                    OP_ADDI:      o_next = S_ADDIEX;
                    OP_J:         o_next = S_JEX;
                    default: begin
                        o_ctrl.illegal   = 1'b1;
                        o_ctrl.instrDone = 1'b1;
                        o_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = ALUSRCB_IMM;
                o_next = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_ctrl.memReq = 1'b1;
                o_ctrl.iord   = 1'b1;
                o_gate.waitReady = 1'b1;
                o_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.memToReg  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.memReq   = 1'b1;
                o_ctrl.memWrite = 1'b1;
                o_ctrl.iord     = 1'b1;
                o_gate.waitReady   = 1'b1;
                o_gate.doneOnReady = 1'b1;
            end
            S_RTYPEEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = ALUSRCB_RT;
                o_ctrl.aluOp   = ALUOP_FUNCT;
                o_next = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.regDst    = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            S_BEQEX: begin
                o_ctrl.aluSrcA   = 1'b1;
                o_ctrl.aluSrcB   = ALUSRCB_RT;
                o_ctrl.aluOp     = ALUOP_SUB;
                o_ctrl.pcSrc     = PCSRC_ALUOUT;
                o_ctrl.instrDone = 1'b1;
                o_gate.beqZeroEn = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = ALUSRCB_IMM;
                o_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            S_JEX: begin
                o_ctrl.pcSrc     = PCSRC_JUMP;
                o_ctrl.pcEn      = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            default: o_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register plus the memory-ready, zero
// and reset gating applied on top of the combinational state decode.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_regwrite,
    output logic       o_pcen,
    output logic       o_iord,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic [1:0] o_aluop,
    output logic       o_instr_done,
    output logic       o_illegal
);

    state_t r_state;
    state_t w_next_decoded;
    state_t w_next;
    ctrl_t  w_ctrl;
    gate_t  w_gate;
    logic   w_live;

    mips_ctrl_decode u_decode (
        .i_state  (r_state),
        .i_opcode (i_opcode),
        .o_ctrl   (w_ctrl),
        .o_gate   (w_gate),
        .o_next   (w_next_decoded)
    );

    // Memory states hold until the access completes
    always_comb begin
        w_next = w_next_decoded;
        if (w_gate.waitReady && !i_mem_ready) begin
            w_next = r_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Enables and pulses are suppressed for the whole reset window
    assign w_live = ~i_reset;

    assign o_mem_req    = w_ctrl.memReq;
    assign o_iord       = w_ctrl.iord;
    assign o_alusrca    = w_ctrl.aluSrcA;
    assign o_alusrcb    = w_ctrl.aluSrcB;
    assign o_pcsrc      = w_ctrl.pcSrc;
    assign o_regdst     = w_ctrl.regDst;
    assign o_memtoreg   = w_ctrl.memToReg;
    assign o_aluop      = w_ctrl.aluOp;
    assign o_memwrite   = w_live & w_ctrl.memWrite;
    assign o_regwrite   = w_live & w_ctrl.regWrite;
    assign o_irwrite    = w_live & w_gate.fetchEn & i_mem_ready;
    assign o_pcen       = w_live & (w_ctrl.pcEn
                                    | (w_gate.fetchEn & i_mem_ready)
                                    | (w_gate.beqZeroEn & i_zero));
    assign o_instr_done = w_live & (w_ctrl.instrDone
                                    | (w_gate.doneOnReady & i_mem_ready));
    assign o_illegal    = w_live & w_ctrl.illegal;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control: each scenario
// drives one cycle per row and compares the full control word against hand values.
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [16:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       memReady = 1'b0;
    logic       memReq, memWrite, irWrite, regWrite, pcEn, iord, aluSrcA;
    logic [1:0] aluSrcB, pcSrc, aluOp;
    logic       regDst, memToReg, instrDone, illegal;
    logic [16:0] obs;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    logic [16:0] F0, F1, DEC, DECI, MADR, MACC, MWB, MWR0, MWR1;
    logic [16:0] REX, RWB, BEQ1, BEQ0, AEX, AWB, JEX;

    mips_multicycle_control dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_opcode     (opcode),
        .i_zero       (zero),
        .i_mem_ready  (memReady),
        .o_mem_req    (memReq),
        .o_memwrite   (memWrite),
        .o_irwrite    (irWrite),
        .o_regwrite   (regWrite),
        .o_pcen       (pcEn),
        .o_iord       (iord),
        .o_alusrca    (aluSrcA),
        .o_alusrcb    (aluSrcB),
        .o_pcsrc      (pcSrc),
        .o_regdst     (regDst),
        .o_memtoreg   (memToReg),
        .o_aluop      (aluOp),
        .o_instr_done (instrDone),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign obs = {memReq, memWrite, irWrite, regWrite, pcEn, iord, aluSrcA,
                  aluSrcB, pcSrc, regDst, memToReg, aluOp, instrDone, illegal};

    function automatic logic [16:0] v(input logic mreq, input logic mw, input logic irw,
                                      input logic rw, input logic pce, input logic io,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic rd,
                                      input logic m2r, input logic [1:0] aop,
                                      input logic done, input logic ill);
        return {mreq, mw, irw, rw, pce, io, asa, asb, pcs, rd, m2r, aop, done, ill};
    endfunction

    // Inputs change on the falling edge; outputs are observed 1 time unit later
    task automatic applyStimulus(input logic rst, input logic rdy, input logic z,
                                 input logic [5:0] op);
        @(negedge clk);
        reset    = rst;
        memReady = rdy;
        zero     = z;
        opcode   = op;
        #1;
    endtask

    task automatic addVec(input logic rst, input logic rdy, input logic z,
                          input logic [5:0] op, input logic [16:0] exp);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.z = z; e.op = op; e.exp = exp;
        vecs.push_back(e);
    endtask

    task automatic test_reset();
        vecs.delete();
        addVec(1, 0, 0, OP_J, F0);
        addVec(1, 1, 0, OP_J, F0);
        addVec(0, 0, 0, OP_J, F0);
        addVec(0, 1, 0, OP_J, F1);
        addVec(0, 0, 0, OP_J, DEC);
        addVec(0, 1, 0, OP_J, JEX);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_rtype();
        int doneCnt = 0;
        vecs.delete();
        addVec(0, 1, 0, OP_R, F1);
        addVec(0, 1, 0, OP_R, DEC);
        addVec(0, 1, 0, OP_R, REX);
        addVec(0, 1, 0, OP_R, RWB);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            doneCnt += int'(instrDone);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL rtype cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
        checks++;
        if (doneCnt !== 1) begin
            errors++;
            $display("[TB] FAIL rtype_done_count: got %0d want 1", doneCnt);
        end
    endtask

    task automatic test_lw_wait();
        int irwCnt = 0;
        int pceCnt = 0;
        int rwCnt = 0;
        vecs.delete();
        addVec(0, 0, 0, OP_LW, F0);
        addVec(0, 0, 0, OP_LW, F0);
        addVec(0, 1, 0, OP_LW, F1);
        addVec(0, 1, 0, OP_LW, DEC);
        addVec(0, 1, 0, OP_LW, MADR);
        addVec(0, 0, 0, OP_LW, MACC);
        addVec(0, 0, 0, OP_LW, MACC);
        addVec(0, 1, 0, OP_LW, MACC);
        addVec(0, 1, 0, OP_LW, MWB);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            irwCnt += int'(irWrite);
            pceCnt += int'(pcEn);
            rwCnt  += int'(regWrite & memToReg);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL lw_wait cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
        checks++;
        if (irwCnt !== 1 || pceCnt !== 1 || rwCnt !== 1) begin
            errors++;
            $display("[TB] FAIL lw_pulse_counts: got irw=%0d pcen=%0d rw=%0d want 1 1 1",
                     irwCnt, pceCnt, rwCnt);
        end
    endtask

    task automatic test_beq();
        vecs.delete();
        addVec(0, 1, 0, OP_BEQ, F1);
        addVec(0, 0, 0, OP_BEQ, DEC);
        addVec(0, 0, 1, OP_BEQ, BEQ1);
        addVec(0, 1, 1, OP_BEQ, F1);
        addVec(0, 1, 0, OP_BEQ, DEC);
        addVec(0, 1, 0, OP_BEQ, BEQ0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL beq cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_sw();
        vecs.delete();
        addVec(0, 1, 0, OP_SW, F1);
        addVec(0, 0, 0, OP_SW, DEC);
        addVec(0, 1, 0, OP_SW, MADR);
        addVec(0, 0, 0, OP_SW, MWR0);
        addVec(0, 1, 0, OP_SW, MWR1);
        addVec(0, 0, 0, OP_SW, F0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL sw cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vecs.delete();
        addVec(0, 1, 0, OP_ADDI, F1);
        addVec(0, 1, 0, OP_ADDI, DEC);
        addVec(0, 1, 0, OP_ADDI, AEX);
        addVec(0, 1, 0, OP_ADDI, AWB);
        addVec(0, 1, 0, OP_J, F1);
        addVec(0, 1, 0, OP_J, DEC);
        addVec(0, 0, 0, OP_J, JEX);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL addi_j cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        vecs.delete();
        addVec(0, 1, 0, OP_BAD, F1);
        addVec(0, 1, 0, OP_BAD, DECI);
        addVec(0, 0, 0, OP_BAD, F0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL illegal cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid_memrd();
        int rwCnt = 0;
        vecs.delete();
        addVec(0, 1, 0, OP_LW, F1);
        addVec(0, 1, 0, OP_LW, DEC);
        addVec(0, 1, 0, OP_LW, MADR);
        addVec(0, 0, 0, OP_LW, MACC);
        addVec(1, 1, 0, OP_LW, MACC);
        addVec(1, 1, 0, OP_LW, F0);
        addVec(1, 1, 0, OP_LW, F0);
        addVec(0, 0, 0, OP_LW, F0);
        addVec(0, 1, 0, OP_J, F1);
        addVec(0, 0, 0, OP_J, DEC);
        addVec(0, 0, 0, OP_J, JEX);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].z, vecs[i].op);
            rwCnt += int'(regWrite);
            checks++;
            if (obs !== vecs[i].exp) begin
                errors++;
                $display("[TB] FAIL reset_memrd cycle %0d: got %b want %b", i, obs, vecs[i].exp);
            end
        end
        checks++;
        if (rwCnt !== 0) begin
            errors++;
            $display("[TB] FAIL reset_memrd_regwrite: got %0d pulses want 0", rwCnt);
        end
    endtask

    initial begin
        F0   = v(1,0,0,0,0,0,0,2'b01,2'b00,0,0,2'b00,0,0);
        F1   = v(1,0,1,0,1,0,0,2'b01,2'b00,0,0,2'b00,0,0);
        DEC  = v(0,0,0,0,0,0,0,2'b11,2'b00,0,0,2'b00,0,0);
        DECI = v(0,0,0,0,0,0,0,2'b11,2'b00,0,0,2'b00,1,1);
        MADR = v(0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00,0,0);
        MACC = v(1,0,0,0,0,1,0,2'b00,2'b00,0,0,2'b00,0,0);
        MWB  = v(0,0,0,1,0,0,0,2'b00,2'b00,0,1,2'b00,1,0);
        MWR0 = v(1,1,0,0,0,1,0,2'b00,2'b00,0,0,2'b00,0,0);
        MWR1 = v(1,1,0,0,0,1,0,2'b00,2'b00,0,0,2'b00,1,0);
        REX  = v(0,0,0,0,0,0,1,2'b00,2'b00,0,0,2'b10,0,0);
        RWB  = v(0,0,0,1,0,0,0,2'b00,2'b00,1,0,2'b00,1,0);
        BEQ1 = v(0,0,0,0,1,0,1,2'b00,2'b01,0,0,2'b01,1,0);
        BEQ0 = v(0,0,0,0,0,0,1,2'b00,2'b01,0,0,2'b01,1,0);
        AEX  = v(0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00,0,0);
        AWB  = v(0,0,0,1,0,0,0,2'b00,2'b00,0,0,2'b00,1,0);
        JEX  = v(0,0,0,0,1,0,0,2'b00,2'b10,0,0,2'b00,1,0);

        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_sw();
        test_back_to_back();
        test_illegal();
        test_reset_mid_memrd();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
